// File: rtl/match_seq_ctrl_pkg.sv
// Shared types and constants for the match sequencing controller.
// State encoding, default code width, trigger pattern and reset code.
package match_seq_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CAP  = 2'd1,
    RESP = 2'd2,
    LOCK = 2'd3
  } state_t;

  localparam int          CW_DEF   = 4;
  localparam logic [3:0]  TRIG_PAT = 4'b1011;
  localparam int          RST_CODE = 0;

endpackage

// File: rtl/match_seq_ctrl_idx_encd.sv
// Combinational log2-plus-one index encoder: 0 for zero, else MSB position + 1.
// Zero latency; no flow control, purely combinational.
module idx_encd
  import match_seq_ctrl_pkg::*;
#(
  parameter int IW = 10,
  parameter int CW = CW_DEF
) (
  input  logic [IW-1:0] i,
  output logic [CW-1:0] code
);

  always_comb begin
    code = CW'(RST_CODE);
    // Later (higher) set bits overwrite earlier ones, leaving the MSB position.
    for (int b = 0; b < IW; b++) begin
      if (i[b]) code = CW'(b + 1);
    end
  end

endmodule

// File: rtl/match_seq_ctrl.sv
// Enroll/check sequencer with failure lockout; enroll answers 1 cycle, check 2 cycles after sampling.
// No queuing: requests are only sampled in IDLE and dropped otherwise; busy marks non-IDLE.
module match_seq_ctrl
  import match_seq_ctrl_pkg::*;
#(
  parameter int IW       = 10,
  parameter int CW       = CW_DEF,
  parameter int MAX_FAIL = 3,
  parameter int LOCK_CYC = 16
) (
  input  logic          c,
  input  logic          rn,
  input  logic [IW-1:0] i,
  input  logic          enr,
  input  logic          chk,
  output logic          busy,
  output logic          done,
  output logic          match,
  output logic          err,
  output logic          tamper,
  output logic          locked,
  output logic [CW-1:0] fail_cnt,
  output logic [CW-1:0] ref_code,
  output logic          ref_vld
);

  localparam int          LW       = $clog2(LOCK_CYC + 1);
  localparam logic [CW-1:0] FAIL_MAX = CW'(MAX_FAIL);
  localparam logic [LW-1:0] LOCK_LAST = LW'(LOCK_CYC - 1);

  state_t          state;
  logic [LW-1:0]   lock_cnt;
  logic [CW-1:0]   cap_code;
  logic            cap_trig;
  logic [CW-1:0]   enc_code;
  logic [CW-1:0]   fail_next;

  idx_encd #(.IW(IW), .CW(CW)) u_enc (
    .i    (i),
    .code (enc_code)
  );

  assign fail_next = (fail_cnt == FAIL_MAX) ? FAIL_MAX : fail_cnt + CW'(1);

  always_ff @(posedge c) begin
    if (!rn) begin
      state    <= IDLE;
      lock_cnt <= '0;
      cap_code <= CW'(RST_CODE);
      cap_trig <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      match    <= 1'b0;
      err      <= 1'b0;
      tamper   <= 1'b0;
      locked   <= 1'b0;
      fail_cnt <= '0;
      ref_code <= CW'(RST_CODE);
      ref_vld  <= 1'b0;
    end else begin
      // Response strobes live only for the single RESP cycle.
      done  <= 1'b0;
      match <= 1'b0;
      err   <= 1'b0;
      case (state)
        IDLE: begin
          if (enr) begin
            ref_code <= enc_code;
            ref_vld  <= 1'b1;
            done     <= 1'b1;
            busy     <= 1'b1;
            state    <= RESP;
          end else if (chk) begin
            cap_code <= enc_code;
            cap_trig <= (i[3:0] == TRIG_PAT);
            busy     <= 1'b1;
            state    <= CAP;
          end
        end
        CAP: begin
          done  <= 1'b1;
          state <= RESP;
          if (!ref_vld) begin
            err <= 1'b1;
          end else if (cap_trig) begin
            // Trigger pattern is never allowed to match, even on equal codes.
            tamper   <= 1'b1;
            fail_cnt <= fail_next;
          end else if (cap_code == ref_code) begin
            match    <= 1'b1;
            fail_cnt <= '0;
          end else begin
            fail_cnt <= fail_next;
          end
        end
        RESP: begin
          if (fail_cnt == FAIL_MAX) begin
            locked <= 1'b1;
            state  <= LOCK;
          end else begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        LOCK: begin
          if (lock_cnt == LOCK_LAST) begin
            lock_cnt <= '0;
            fail_cnt <= '0;
            locked   <= 1'b0;
            busy     <= 1'b0;
            state    <= IDLE;
          end else begin
            lock_cnt <= lock_cnt + LW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
